// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared constants and time type for the alarm clock
//
// Purpose: BCD digit width, digit limits, hour bounds, reset times and the
//          packed HH:MM time type shared by the time counter, alarm
//          register and display driver.
// Ports:   none (package).
package alarm_pkg;

    localparam int DIGIT_W = 4;

    // Per-digit limits.
    localparam logic [DIGIT_W-1:0] DIGIT_MAX      = 4'd9;  // any BCD digit
    localparam logic [DIGIT_W-1:0] MS_MIN_MAX     = 4'd5;  // minutes tens
    localparam logic [DIGIT_W-1:0] MS_HOUR_MAX_24 = 4'd2;  // hours tens, 24h
    localparam logic [DIGIT_W-1:0] LS_HOUR_LAST_24 = 4'd3; // units at 2x, 24h
    localparam logic [DIGIT_W-1:0] MS_HOUR_MAX_12 = 4'd1;  // hours tens, 12h

    // Whole-hour bounds, as binary hour values.
    localparam logic [7:0] HOUR24_MIN = 8'd0;
    localparam logic [7:0] HOUR24_MAX = 8'd23;
    localparam logic [7:0] HOUR12_MIN = 8'd1;
    localparam logic [7:0] HOUR12_MAX = 8'd12;

    typedef struct packed {
        logic [DIGIT_W-1:0] ms_hour;
        logic [DIGIT_W-1:0] ls_hour;
        logic [DIGIT_W-1:0] ms_min;
        logic [DIGIT_W-1:0] ls_min;
    } bcd_time_t;

    localparam bcd_time_t RESET_TIME_24 = '{4'd0, 4'd0, 4'd0, 4'd0}; // 00:00
    localparam bcd_time_t RESET_TIME_12 = '{4'd1, 4'd2, 4'd0, 4'd0}; // 12:00

    // Binary value of a two-digit BCD hour; only meaningful when both
    // digits are already known to be <= 9.
    function automatic logic [7:0] hour_value(input logic [DIGIT_W-1:0] ms,
                                              input logic [DIGIT_W-1:0] ls);
        return ({4'd0, ms} * 8'd10) + {4'd0, ls};
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - single BCD digit with load, terminal and wrap
//
// Purpose: one registered BCD digit. Counts up on inc, returns to wrap after
//          reaching terminal, and takes load_value when load is high (load
//          wins over inc).
// Ports:   clock, reset (async, active-high)
//          inc        increment enable
//          load       parallel load enable
//          load_value value taken on load
//          terminal   last value before wrapping
//          wrap       value following terminal
//          digit      current digit (registered)
//          carry      high when this edge wraps the digit
module bcd_digit_counter
    import alarm_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] RESET_VALUE = 4'd0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inc,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_value,
    input  logic [DIGIT_W-1:0] terminal,
    input  logic [DIGIT_W-1:0] wrap,
    output logic [DIGIT_W-1:0] digit,
    output logic               carry
);

    logic at_terminal;

    assign at_terminal = (digit == terminal);
    // A load suppresses the increment, so it must also suppress the carry.
    assign carry       = inc && !load && at_terminal;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            digit <= RESET_VALUE;
        end else if (load) begin
            digit <= load_value;
        end else if (inc) begin
            digit <= at_terminal ? wrap : digit + 4'd1;
        end
    end

endmodule

// File: rtl/time_counter.sv
// rtl/time_counter.sv - HH:MM BCD time-of-day register with validated load
//
// Purpose: advances a four-digit BCD clock on one_minute, accepts a checked
//          parallel load, and pulses reset_count / load_error / rollover for
//          one cycle after the causing edge.
// Ports:   clock, reset (async, active-high)
//          one_minute     minute advance strobe
//          load_new_time  load request; new_* carry the value
//          new_ms_hour, new_ls_hour, new_ms_min, new_ls_min, new_pm
//          ms_hour, ls_hour, ms_min, ls_min, pm   current time (registered)
//          reset_count    pulse after an accepted load
//          load_error     pulse after a rejected load
//          rollover       pulse when the clock wraps to start of day
module time_counter
    import alarm_pkg::*;
#(
    parameter bit MODE24 = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               one_minute,
    input  logic               load_new_time,
    input  logic [DIGIT_W-1:0] new_ms_hour,
    input  logic [DIGIT_W-1:0] new_ls_hour,
    input  logic [DIGIT_W-1:0] new_ms_min,
    input  logic [DIGIT_W-1:0] new_ls_min,
    input  logic               new_pm,
    output logic [DIGIT_W-1:0] ms_hour,
    output logic [DIGIT_W-1:0] ls_hour,
    output logic [DIGIT_W-1:0] ms_min,
    output logic [DIGIT_W-1:0] ls_min,
    output logic               pm,
    output logic               reset_count,
    output logic               load_error,
    output logic               rollover
);

    localparam bcd_time_t RESET_TIME = MODE24 ? RESET_TIME_24 : RESET_TIME_12;

    logic               digits_ok;
    logic               hour_ok;
    logic               load_valid;
    logic               accept_load;
    logic               advance;
    logic               ls_min_carry;
    logic               hour_inc;
    logic [7:0]         new_hour;
    logic [DIGIT_W-1:0] ms_hour_next;
    logic [DIGIT_W-1:0] ls_hour_next;
    logic               pm_next;
    logic               day_wrap;

    // ---------------------------------------------------------------- load check
    always_comb begin
        digits_ok = (new_ms_hour <= DIGIT_MAX) && (new_ls_hour <= DIGIT_MAX) &&
                    (new_ms_min  <= MS_MIN_MAX) && (new_ls_min  <= DIGIT_MAX);
        new_hour  = hour_value(new_ms_hour, new_ls_hour);
        if (MODE24) begin
            hour_ok = (new_hour >= HOUR24_MIN) && (new_hour <= HOUR24_MAX);
        end else begin
            hour_ok = (new_hour >= HOUR12_MIN) && (new_hour <= HOUR12_MAX);
        end
        // hour_value is garbage for non-BCD digits, so digits_ok gates it.
        load_valid = digits_ok && hour_ok;
    end

    assign accept_load = load_new_time && load_valid;
    // Any load request, valid or not, swallows a coincident strobe.
    assign advance     = one_minute && !load_new_time;

    // ---------------------------------------------------------------- minutes
    bcd_digit_counter #(
        .RESET_VALUE (RESET_TIME.ls_min)
    ) u_ls_min (
        .clock      (clock),
        .reset      (reset),
        .inc        (advance),
        .load       (accept_load),
        .load_value (new_ls_min),
        .terminal   (DIGIT_MAX),
        .wrap       (4'd0),
        .digit      (ls_min),
        .carry      (ls_min_carry)
    );

    bcd_digit_counter #(
        .RESET_VALUE (RESET_TIME.ms_min)
    ) u_ms_min (
        .clock      (clock),
        .reset      (reset),
        .inc        (ls_min_carry),
        .load       (accept_load),
        .load_value (new_ms_min),
        .terminal   (MS_MIN_MAX),
        .wrap       (4'd0),
        .digit      (ms_min),
        .carry      (hour_inc)
    );

    // ---------------------------------------------------------------- hours
    // Both hour digits are decided together because the wrap points (23->00,
    // 09->10, 11->12, 12->01) depend on the pair.
    always_comb begin
        ms_hour_next = ms_hour;
        ls_hour_next = ls_hour;
        pm_next      = pm;
        day_wrap     = 1'b0;
        if (MODE24) begin
            if (ms_hour == MS_HOUR_MAX_24 && ls_hour == LS_HOUR_LAST_24) begin
                ms_hour_next = 4'd0;
                ls_hour_next = 4'd0;
                day_wrap     = 1'b1;
            end else if (ls_hour == DIGIT_MAX) begin
                ms_hour_next = ms_hour + 4'd1;
                ls_hour_next = 4'd0;
            end else begin
                ls_hour_next = ls_hour + 4'd1;
            end
        end else begin
            if (ms_hour == 4'd0 && ls_hour == DIGIT_MAX) begin
                ms_hour_next = MS_HOUR_MAX_12;
                ls_hour_next = 4'd0;
            end else if (ms_hour == MS_HOUR_MAX_12 && ls_hour == 4'd1) begin
                // 11 -> 12 is the half-day boundary; PM -> AM is midnight.
                ls_hour_next = 4'd2;
                pm_next      = !pm;
                day_wrap     = pm;
            end else if (ms_hour == MS_HOUR_MAX_12 && ls_hour == 4'd2) begin
                ms_hour_next = 4'd0;
                ls_hour_next = 4'd1;
            end else begin
                ls_hour_next = ls_hour + 4'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ms_hour     <= RESET_TIME.ms_hour;
            ls_hour     <= RESET_TIME.ls_hour;
            pm          <= 1'b0;
            reset_count <= 1'b0;
            load_error  <= 1'b0;
            rollover    <= 1'b0;
        end else begin
            reset_count <= accept_load;
            load_error  <= load_new_time && !load_valid;
            rollover    <= hour_inc && day_wrap;
            if (accept_load) begin
                ms_hour <= new_ms_hour;
                ls_hour <= new_ls_hour;
                pm      <= MODE24 ? 1'b0 : new_pm;
            end else if (hour_inc) begin
                ms_hour <= ms_hour_next;
                ls_hour <= ls_hour_next;
                pm      <= pm_next;
            end
        end
    end

endmodule

// File: tb/tb_time_counter.sv
// tb/tb_time_counter.sv - directed table-driven bench for time_counter
module tb_time_counter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  new_ms_hour = 4'd0, new_ls_hour = 4'd0;
    logic [3:0]  new_ms_min = 4'd0, new_ls_min = 4'd0;
    logic        new_pm = 1'b0;
    logic        ld24 = 1'b0, om24 = 1'b0, ld12 = 1'b0, om12 = 1'b0;

    logic [3:0]  mh24, lh24, mm24, lm24, mh12, lh12, mm12, lm12;
    logic        pm24, rc24, err24, ro24, pm12, rc12, err12, ro12;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    time_counter #(.MODE24(1'b1)) u24 (
        .clock(clock), .reset(reset), .one_minute(om24), .load_new_time(ld24),
        .new_ms_hour(new_ms_hour), .new_ls_hour(new_ls_hour),
        .new_ms_min(new_ms_min), .new_ls_min(new_ls_min), .new_pm(new_pm),
        .ms_hour(mh24), .ls_hour(lh24), .ms_min(mm24), .ls_min(lm24), .pm(pm24),
        .reset_count(rc24), .load_error(err24), .rollover(ro24)
    );

    time_counter #(.MODE24(1'b0)) u12 (
        .clock(clock), .reset(reset), .one_minute(om12), .load_new_time(ld12),
        .new_ms_hour(new_ms_hour), .new_ls_hour(new_ls_hour),
        .new_ms_min(new_ms_min), .new_ls_min(new_ls_min), .new_pm(new_pm),
        .ms_hour(mh12), .ls_hour(lh12), .ms_min(mm12), .ls_min(lm12), .pm(pm12),
        .reset_count(rc12), .load_error(err12), .rollover(ro12)
    );

    typedef struct {
        bit          m12;
        bit          ld;
        bit          om;
        logic [15:0] t;
        bit          npm;
        logic [15:0] et;
        bit          epm;
        bit          erc;
        bit          eerr;
        bit          eroll;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit m12, bit ld, bit om, logic [15:0] t, bit npm,
                                logic [15:0] et, bit epm, bit erc, bit eerr, bit eroll);
        vec_t v;
        v.m12 = m12; v.ld = ld; v.om = om; v.t = t; v.npm = npm;
        v.et = et; v.epm = epm; v.erc = erc; v.eerr = eerr; v.eroll = eroll;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        logic [15:0] at;
        logic        apm, arc, aerr, aro;
        @(negedge clock);
        {new_ms_hour, new_ls_hour, new_ms_min, new_ls_min} = v.t;
        new_pm = v.npm;
        ld24 = !v.m12 && v.ld;  om24 = !v.m12 && v.om;
        ld12 =  v.m12 && v.ld;  om12 =  v.m12 && v.om;
        @(posedge clock);
        #1;
        ld24 = 1'b0; om24 = 1'b0; ld12 = 1'b0; om12 = 1'b0;
        if (v.m12) begin
            at = {mh12, lh12, mm12, lm12}; apm = pm12; arc = rc12; aerr = err12; aro = ro12;
        end else begin
            at = {mh24, lh24, mm24, lm24}; apm = pm24; arc = rc24; aerr = err24; aro = ro24;
        end
        check($sformatf("v%0d_time", idx), at, v.et);
        check($sformatf("v%0d_pm", idx), {15'd0, apm}, {15'd0, v.epm});
        check($sformatf("v%0d_reset_count", idx), {15'd0, arc}, {15'd0, v.erc});
        check($sformatf("v%0d_load_error", idx), {15'd0, aerr}, {15'd0, v.eerr});
        check($sformatf("v%0d_rollover", idx), {15'd0, aro}, {15'd0, v.eroll});
    endtask

    initial begin
        //                m12 ld om  load     npm exp      epm rc err roll
        vecs.push_back(mk(0, 1, 0, 16'h2358, 0, 16'h2358, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h2358, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0000, 0, 16'h2359, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0000, 0, 16'h0000, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h2400, 0, 16'h0000, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 16'h1960, 0, 16'h0000, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0A00, 0, 16'h0000, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 16'h2400, 0, 16'h0000, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0959, 0, 16'h0959, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0000, 0, 16'h1000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 16'h1000, 0, 16'h1000, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h1000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h2359, 1, 16'h2359, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h1934, 0, 16'h1934, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h1934, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0000, 0, 16'h1935, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 16'h1159, 1, 16'h1159, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 16'h0000, 0, 16'h1200, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h1200, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 16'h1259, 0, 16'h1259, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 16'h0000, 0, 16'h0100, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 16'h1159, 0, 16'h1159, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 16'h0000, 0, 16'h1200, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0030, 0, 16'h1200, 1, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 16'h1300, 0, 16'h1200, 1, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0959, 1, 16'h0959, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 16'h0000, 0, 16'h1000, 1, 0, 0, 0));

        // Reset values, sampled while reset is held.
        repeat (2) @(posedge clock);
        #1;
        check("rst24_time", {mh24, lh24, mm24, lm24}, 16'h0000);
        check("rst24_pulses", {13'd0, rc24, err24, ro24}, 16'h0000);
        check("rst12_time", {mh12, lh12, mm12, lm12}, 16'h1200);
        check("rst12_pm_pulses", {12'd0, pm12, rc12, err12, ro12}, 16'h0000);
        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i]) apply(vecs[i], i);

        // Strobe held high for 60 cycles: 05:00 -> 06:00.
        apply(mk(0, 1, 0, 16'h0500, 0, 16'h0500, 0, 1, 0, 0), 100);
        @(negedge clock);
        om24 = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock);
            #1;
            if (i == 14) check("hold_mid", {mh24, lh24, mm24, lm24}, 16'h0515);
        end
        om24 = 1'b0;
        check("hold_end", {mh24, lh24, mm24, lm24}, 16'h0600);

        // Asynchronous reset while reset_count is high.
        apply(mk(0, 1, 0, 16'h0800, 0, 16'h0800, 0, 1, 0, 0), 101);
        #2;
        reset = 1'b1;
        #1;
        check("areset_rc", {15'd0, rc24}, 16'h0000);
        check("areset_time24", {mh24, lh24, mm24, lm24}, 16'h0000);
        check("areset_time12", {mh12, lh12, mm12, lm12, 3'd0, pm12} >> 4, 16'h1200);
        check("areset_pm12", {15'd0, pm12}, 16'h0000);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("post_reset_time24", {mh24, lh24, mm24, lm24}, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
